// File: rtl/uart_tx_frame_ctrl.sv
// UART TX frame controller: latches a byte, sequences the serializer and
// muxes start/data/parity/stop bits onto the idle-high TX line.
//
// Ports:
//   clk        in   bit clock (one cycle = one bit time)
//   rst        in   asynchronous active-low reset
//   P_DATA     in   byte to send, sampled on acceptance
//   Data_Valid in   send request, level-sampled while idle
//   PAR_EN     in   append parity bit, sampled on acceptance
//   PAR_TYP    in   0 = even, 1 = odd parity, sampled on acceptance
//   ser_data   in   registered serial bit from the serializer
//   ser_done   in   high while bit 7 is on ser_data
//   ser_en     out  serializer enable
//   ser_p_data out  latched byte, stable for the whole frame
//   TX_OUT     out  UART line, idle high
//   busy       out  frame in progress
module uart_tx_frame_ctrl #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_DATA,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       ser_en,
    output logic [7:0] ser_p_data,
    output logic       TX_OUT,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_data;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_stop_cnt;
    logic       w_par;
    logic       w_stop_last;
    logic       w_accept;

    assign w_accept    = (r_state == S_IDLE) && Data_Valid;
    assign w_par       = r_par_typ ? ~^r_data : ^r_data;
    assign w_stop_last = (r_stop_cnt == 1'(STOP_BITS - 1));
    assign ser_p_data  = r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Frame attributes are captured only on acceptance so that
    // mid-frame input changes cannot corrupt the frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= 8'h00;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_accept) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stop_cnt <= 1'b0;
        end else if (r_state == S_STOP && !w_stop_last) begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
        end else begin
            r_stop_cnt <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        TX_OUT = 1'b1;
        busy   = 1'b1;
        ser_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (Data_Valid) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                TX_OUT = 1'b0;
                ser_en = 1'b1;
                w_next = S_DATA;
            end
            S_DATA: begin
                // Dropping ser_en with ser_done stops the serializer
                // right after it presents bit 7.
                TX_OUT = ser_data;
                ser_en = ~ser_done;
                if (ser_done) begin
                    w_next = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                TX_OUT = w_par;
                w_next = S_STOP;
            end
            S_STOP: begin
                if (w_stop_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
